// File: rtl/dkongjr_snd_pkg.sv
// dkongjr_snd_pkg
// Shared definitions for the Donkey Kong Jr. sound scheduler: decay FSM
// state encoding, DAC silence level, DAC source encoding and a saturating
// increment for the 16-bit tick counter.
package dkongjr_snd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PLAY  = 3'd1,
        ST_HOLD  = 3'd2,
        ST_DECAY = 3'd3,
        ST_MUTE  = 3'd4
    } snd_state_t;

    // Mid-scale of the offset-binary DAC.
    localparam logic [7:0] SND_SILENCE = 8'h80;

    // DAC grant encoding as seen on O_SRC.
    localparam logic SRC_CPU = 1'b0;
    localparam logic SRC_SMP = 1'b1;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/dkongjr_snd_tick.sv
// dkongjr_snd_tick
// Sample-rate divider. The counter runs 0..SAMPLE_CNT-1 and wraps; strobe is
// high in the cycle right after the wrap and tick follows one cycle later.
// Consumers that must present a registered result during the tick cycle make
// their decision on strobe, so both edges share one tick definition.
// Ports:
//   clk    - clock
//   rst_n  - asynchronous active-low reset
//   strobe - decision strobe, one cycle ahead of tick
//   tick   - one-cycle sample tick
module dkongjr_snd_tick #(
    parameter int SAMPLE_CNT = 1114
) (
    input  logic clk,
    input  logic rst_n,
    output logic strobe,
    output logic tick
);

    localparam int CW = (SAMPLE_CNT > 1) ? $clog2(SAMPLE_CNT) : 1;
    localparam logic [CW-1:0] LAST = CW'(SAMPLE_CNT - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            strobe <= 1'b0;
            tick   <= 1'b0;
        end else begin
            cnt    <= (cnt == LAST) ? '0 : cnt + 1'b1;
            strobe <= (cnt == LAST);
            tick   <= strobe;
        end
    end

endmodule

// File: rtl/dkongjr_snd_sched.sv
// dkongjr_snd_sched
// Sample-rate scheduler/arbiter in front of the DK Jr. sound DAC. Shares the
// 8-bit DAC input between the sound-CPU latch and an optional sample
// requester, and sequences the decay-enable line (hold, decay, mute).
// All output updates land in the O_TICK cycle: decisions are taken on the
// clock edge that raises O_TICK, using the inputs sampled on that edge.
// Build option: define DKJR_SND_SMP_EN to include the sample requester and
// the arbiter; without it the sample inputs are ignored, O_SRC/O_SMP_ACK are
// 0 and the decay FSM runs unconditionally.
// Ports:
//   I_CLK, I_RESET_n        - clock, asynchronous active-low reset
//   I_CPU_WR, I_CPU_DAT     - sound-CPU DAC write strobe and value
//   I_DECAY_REQ             - decay request level from the sound latch
//   I_SMP_REQ, I_SMP_DAT    - sample available (level) and its value
//   O_SMP_ACK               - one-cycle pulse, sample value consumed
//   O_SND_DAT               - value to the DAC/decay stage
//   O_DECAY_EN              - decay enable to the envelope stage
//   O_SRC                   - current grant, 0 = CPU, 1 = sample
//   O_TICK                  - one-cycle sample tick
module dkongjr_snd_sched #(
    parameter int SAMPLE_CNT = 1114,
    parameter int HOLD_TICKS = 142,
    parameter int MUTE_TICKS = 6112,
    parameter int GRANT_MIN  = 8
) (
    input  logic       I_CLK,
    input  logic       I_RESET_n,
    input  logic       I_CPU_WR,
    input  logic [7:0] I_CPU_DAT,
    input  logic       I_DECAY_REQ,
    input  logic       I_SMP_REQ,
    input  logic [7:0] I_SMP_DAT,
    output logic       O_SMP_ACK,
    output logic [7:0] O_SND_DAT,
    output logic       O_DECAY_EN,
    output logic       O_SRC,
    output logic       O_TICK
);

    import dkongjr_snd_pkg::*;

    localparam logic [15:0] HOLD_LAST = 16'(HOLD_TICKS - 1);
    localparam logic [15:0] MUTE_LAST = 16'(MUTE_TICKS - 1);

    // dec: decision cycle, one cycle ahead of O_TICK
    logic dec;

    dkongjr_snd_tick #(.SAMPLE_CNT(SAMPLE_CNT)) u_tick (
        .clk    (I_CLK),
        .rst_n  (I_RESET_n),
        .strobe (dec),
        .tick   (O_TICK)
    );

    // CPU latch; a write coincident with the decision is used at once.
    logic [7:0] cpu_reg;
    logic [7:0] cpu_next;

    assign cpu_next = I_CPU_WR ? I_CPU_DAT : cpu_reg;

    always_ff @(posedge I_CLK or negedge I_RESET_n) begin
        if (!I_RESET_n) cpu_reg <= SND_SILENCE;
        else            cpu_reg <= cpu_next;
    end

    // ---------------------------------------------------------------
    // Arbiter
    // ---------------------------------------------------------------
    logic src;       // current grant
    logic src_n;     // grant after this decision
    logic smp_take;  // sample consumed on this decision

`ifdef DKJR_SND_SMP_EN
    localparam int DW = (GRANT_MIN > 0) ? $clog2(GRANT_MIN + 1) : 1;
    localparam logic [DW-1:0] DMAX = DW'(GRANT_MIN);

    logic [DW-1:0] dwell;
    logic          dwell_ok;
    logic          pend;      // CPU write seen since the last decision
    logic          pend_now;

    assign dwell_ok = (dwell >= DMAX);
    assign pend_now = pend | I_CPU_WR;

    always_comb begin
        src_n = src;
        if (dec) begin
            if (src == SRC_CPU) begin
                if (I_SMP_REQ && dwell_ok) src_n = SRC_SMP;
            end else if (!I_SMP_REQ || (dwell_ok && pend_now)) begin
                src_n = SRC_CPU;
            end
        end
    end

    always_ff @(posedge I_CLK or negedge I_RESET_n) begin
        if (!I_RESET_n) begin
            src   <= SRC_CPU;
            dwell <= '0;
            pend  <= 1'b0;
        end else if (dec) begin
            src  <= src_n;
            pend <= 1'b0;
            if (src_n != src)  dwell <= '0;
            else if (!dwell_ok) dwell <= dwell + 1'b1;
        end else if (I_CPU_WR) begin
            pend <= 1'b1;
        end
    end

    // Staying on (or moving to) the sample source implies I_SMP_REQ=1.
    assign smp_take = dec && (src_n == SRC_SMP);
`else
    assign src      = SRC_CPU;
    assign src_n    = SRC_CPU;
    assign smp_take = 1'b0;

    logic unused_smp;
    assign unused_smp = ^{I_SMP_REQ, I_SMP_DAT};
`endif

    // ---------------------------------------------------------------
    // Decay FSM (CPU path)
    // ---------------------------------------------------------------
    snd_state_t  state, state_n;
    logic [15:0] tcnt, tcnt_n;
    logic        frozen;

    assign frozen = (src == SRC_SMP);

    always_ff @(posedge I_CLK or negedge I_RESET_n) begin
        if (!I_RESET_n) begin
            state <= ST_IDLE;
            tcnt  <= 16'd0;
        end else begin
            state <= state_n;
            tcnt  <= tcnt_n;
        end
    end

    always_comb begin
        state_n = state;
        tcnt_n  = tcnt;
        if (frozen) begin
            // Handing the DAC back: any decay phase restarts from PLAY.
            if (dec && (src_n == SRC_CPU)) begin
                if (state != ST_IDLE) state_n = ST_PLAY;
                tcnt_n = 16'd0;
            end
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (I_CPU_WR) state_n = ST_PLAY;
                end
                ST_PLAY: begin
                    if (dec && I_DECAY_REQ) begin
                        state_n = ST_HOLD;
                        tcnt_n  = 16'd0;
                    end
                end
                ST_HOLD: begin
                    if (dec) begin
                        if (!I_DECAY_REQ) begin
                            state_n = ST_PLAY;
                        end else if (I_CPU_WR) begin
                            tcnt_n = 16'd0;           // retrigger wins
                        end else if (tcnt == HOLD_LAST) begin
                            state_n = ST_DECAY;
                            tcnt_n  = 16'd0;
                        end else begin
                            tcnt_n = sat_inc16(tcnt);
                        end
                    end else if (I_CPU_WR) begin
                        tcnt_n = 16'd0;
                    end
                end
                ST_DECAY: begin
                    if (dec) begin
                        if (!I_DECAY_REQ) begin
                            state_n = ST_PLAY;
                        end else if (tcnt == MUTE_LAST) begin
                            state_n = ST_MUTE;
                            tcnt_n  = 16'd0;
                        end else begin
                            tcnt_n = sat_inc16(tcnt);
                        end
                    end
                end
                ST_MUTE: begin
                    if (dec && !I_DECAY_REQ) state_n = ST_IDLE;
                end
                default: begin
                    state_n = ST_IDLE;
                    tcnt_n  = 16'd0;
                end
            endcase
        end
    end

    // ---------------------------------------------------------------
    // Output registers, loaded only on the decision edge
    // ---------------------------------------------------------------
    logic [7:0] snd, snd_n;
    logic       den, den_n;
    logic       ack;

    always_comb begin
        snd_n = (state_n == ST_IDLE || state_n == ST_MUTE) ? SND_SILENCE : cpu_next;
        den_n = (state_n == ST_DECAY || state_n == ST_MUTE);
`ifdef DKJR_SND_SMP_EN
        if (src_n == SRC_SMP) begin
            snd_n = I_SMP_DAT;
            den_n = 1'b0;
        end
`endif
    end

    always_ff @(posedge I_CLK or negedge I_RESET_n) begin
        if (!I_RESET_n) begin
            snd <= SND_SILENCE;
            den <= 1'b0;
            ack <= 1'b0;
        end else begin
            ack <= smp_take;
            if (dec) begin
                snd <= snd_n;
                den <= den_n;
            end
        end
    end

    assign O_SND_DAT  = snd;
    assign O_DECAY_EN = den;
    assign O_SMP_ACK  = ack;
    assign O_SRC      = src;

endmodule

// File: tb/tb_dkongjr_snd_sched.sv
`timescale 1ns/1ps
// Bench for dkongjr_snd_sched with shortened timing parameters. A tick-level
// reference model tracks ticks elapsed since hold/decay start and since the
// last grant change; directed scenarios are followed by random traffic.
module tb_dkongjr_snd_sched;

    localparam int N  = 6;    // SAMPLE_CNT
    localparam int H  = 12;   // HOLD_TICKS
    localparam int M  = 20;   // MUTE_TICKS
    localparam int GM = 8;    // GRANT_MIN

    localparam int S_IDLE = 0, S_PLAY = 1, S_HOLD = 2, S_DECAY = 3, S_MUTE = 4;

    logic       clk = 1'b0, rst_n = 1'b0;
    logic       cpu_wr = 1'b0, decay_req = 1'b0, smp_req = 1'b0;
    logic [7:0] cpu_dat = 8'h00, smp_dat = 8'h00;
    logic       smp_ack, decay_en, src, tick;
    logic [7:0] snd_dat;

    int tests = 0, fails = 0;
    int cyc = 0;
    bit smp_seq = 1'b0;

    // reference model state
    int         m_st, m_age, m_tidx, m_lastsw;
    bit         m_src, m_pend, m_ack, m_den, m_tick;
    logic [7:0] m_cpu, m_snd;

    always #5 clk = ~clk;

    dkongjr_snd_sched #(
        .SAMPLE_CNT(N), .HOLD_TICKS(H), .MUTE_TICKS(M), .GRANT_MIN(GM)
    ) dut (
        .I_CLK(clk), .I_RESET_n(rst_n),
        .I_CPU_WR(cpu_wr), .I_CPU_DAT(cpu_dat),
        .I_DECAY_REQ(decay_req),
        .I_SMP_REQ(smp_req), .I_SMP_DAT(smp_dat),
        .O_SMP_ACK(smp_ack), .O_SND_DAT(snd_dat), .O_DECAY_EN(decay_en),
        .O_SRC(src), .O_TICK(tick)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Decision edges: the edge that raises the tick, N+1 edges after reset
    // release and every N edges after that.
    function automatic bit is_dec(input int c);
        return (c > N) && (((c - 1) % N) == 0);
    endfunction

    task automatic model_reset();
        m_st = S_IDLE; m_age = 0; m_tidx = 0; m_lastsw = 0;
        m_src = 0; m_pend = 0; m_ack = 0; m_den = 0; m_tick = 0;
        m_cpu = 8'h80; m_snd = 8'h80;
    endtask

    task automatic model_edge(input bit dec);
        bit wr, req, pend_now, nsrc;
        logic [7:0] d, sd;
        wr = cpu_wr; d = cpu_dat; req = smp_req; sd = smp_dat;
        m_ack  = 0;
        m_tick = dec;
        if (wr) m_cpu = d;
        if (!dec) begin
            if (wr) m_pend = 1;
            if (!m_src && wr) begin
                if (m_st == S_IDLE)      m_st  = S_PLAY;
                else if (m_st == S_HOLD) m_age = 0;
            end
            return;
        end
        m_tidx++;
        pend_now = m_pend | wr;
        m_pend = 0;
        nsrc = m_src;
`ifdef DKJR_SND_SMP_EN
        if (!m_src) nsrc = req && (m_tidx - m_lastsw - 1 >= GM);
        else        nsrc = req && !((m_tidx - m_lastsw - 1 >= GM) && pend_now);
        if (nsrc != m_src) m_lastsw = m_tidx;
`endif
        if (m_src) begin
            if (!nsrc) begin
                if (m_st != S_IDLE) m_st = S_PLAY;
                m_age = 0;
            end
        end else begin
            case (m_st)
                S_IDLE:  if (wr) m_st = S_PLAY;
                S_PLAY:  if (decay_req) begin m_st = S_HOLD; m_age = 0; end
                S_HOLD:  if (!decay_req) m_st = S_PLAY;
                         else if (wr) m_age = 0;
                         else begin
                             m_age++;
                             if (m_age == H) begin m_st = S_DECAY; m_age = 0; end
                         end
                S_DECAY: if (!decay_req) m_st = S_PLAY;
                         else begin
                             m_age++;
                             if (m_age == M) begin m_st = S_MUTE; m_age = 0; end
                         end
                S_MUTE:  if (!decay_req) m_st = S_IDLE;
                default: m_st = S_IDLE;
            endcase
        end
        m_src = nsrc;
        m_ack = nsrc;
        m_snd = nsrc ? sd : ((m_st == S_IDLE || m_st == S_MUTE) ? 8'h80 : m_cpu);
        m_den = !nsrc && (m_st == S_DECAY || m_st == S_MUTE);
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        model_edge(is_dec(cyc));
        #1;
        chk("tick",     16'(tick),     16'(m_tick));
        chk("snd_dat",  16'(snd_dat),  16'(m_snd));
        chk("decay_en", 16'(decay_en), 16'(m_den));
        chk("src",      16'(src),      16'(m_src));
        chk("smp_ack",  16'(smp_ack),  16'(m_ack));
        if (smp_seq && m_ack) smp_dat = smp_dat + 8'h10;
        cpu_wr = 1'b0;
    endtask

    task automatic to_dec();
        while (!is_dec(cyc + 1)) step();
    endtask

    task automatic tick_step();
        do step(); while (!is_dec(cyc));
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_snd_dat",  16'(snd_dat),  16'h80);
        chk("rst_decay_en", 16'(decay_en), 16'h0);
        chk("rst_src",      16'(src),      16'h0);
        chk("rst_smp_ack",  16'(smp_ack),  16'h0);
        chk("rst_tick",     16'(tick),     16'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        cyc = 0;
    endtask

    task automatic decay_scenario();
        int n, lat;
        repeat ($urandom_range(1, N - 1)) step();
        cpu_dat = 8'hF0; cpu_wr = 1'b1;
        step();
        lat = 1;
        while (snd_dat !== 8'hF0 && lat < 3 * N) begin step(); lat++; end
        chk("cpu_wr_latency_ok", 16'(lat <= N + 1), 16'd1);
        chk("cpu_wr_F0",         16'(snd_dat),      16'hF0);
        to_dec(); decay_req = 1'b1; step();
        n = 0;
        do begin tick_step(); n++; end while (decay_en !== 1'b1 && n < 3 * H);
        chk("decay_after_hold", 16'(n), 16'(H));
        n = 0;
        do begin tick_step(); n++; end while (snd_dat !== 8'h80 && n < 3 * M);
        chk("mute_after_decay", 16'(n),        16'(M));
        chk("mute_decay_en",    16'(decay_en), 16'h1);
        to_dec(); decay_req = 1'b0; step();
        chk("mute_release_dat", 16'(snd_dat),  16'h80);
        chk("mute_release_den", 16'(decay_en), 16'h0);
    endtask

    initial begin
        int first, n;
`ifndef DKJR_SND_SMP_EN
        smp_req = 1'b1;     // ignored when the requester is not built
        smp_dat = 8'h3C;
`endif
        do_reset();

        // first tick timing
        first = 0;
        for (int i = 0; i < 3 * N && first == 0; i++) begin
            step();
            if (tick === 1'b1) first = cyc;
        end
        chk("first_tick_cycle", 16'(first), 16'(N + 1));

        decay_scenario();

        // retrigger in HOLD, then release from DECAY
        cpu_dat = 8'h55; cpu_wr = 1'b1; step();
        tick_step();
        chk("play_55", 16'(snd_dat), 16'h55);
        to_dec(); decay_req = 1'b1; step();
        repeat (H - 5) tick_step();
        to_dec(); cpu_dat = 8'hC0; cpu_wr = 1'b1; step();
        n = 0;
        do begin tick_step(); n++; end while (decay_en !== 1'b1 && n < 3 * H);
        chk("retrigger_delay", 16'(n), 16'(H));
        repeat (3) tick_step();
        to_dec(); decay_req = 1'b0; step();
        chk("release_decay_en", 16'(decay_en), 16'h0);
        chk("release_play_dat", 16'(snd_dat),  16'hC0);

        // asynchronous reset while outputs are non-idle
        do_reset();

`ifdef DKJR_SND_SMP_EN
        cpu_dat = 8'hF0; cpu_wr = 1'b1;
        smp_req = 1'b1; smp_dat = 8'h10; smp_seq = 1'b1; decay_req = 1'b0;
        step();
        n = 0;
        do begin
            tick_step(); n++;
            if (n == 4) decay_req = 1'b1;
        end while (src !== 1'b1 && n < 4 * GM);
        chk("grant_switch_tick", 16'(n),        16'(GM + 1));
        chk("grant_first_dat",   16'(snd_dat),  16'h10);
        chk("grant_first_ack",   16'(smp_ack),  16'h1);
        chk("grant_den_forced",  16'(decay_en), 16'h0);
        for (int k = 1; k <= 5; k++) begin
            tick_step();
            chk("smp_ack_per_tick", 16'(smp_ack),  16'h1);
            chk("smp_dat_seq",      16'(snd_dat),  16'(8'(16 * (k + 1))));
            chk("smp_den_forced",   16'(decay_en), 16'h0);
        end
        smp_seq = 1'b0; smp_req = 1'b0;
        tick_step();
        chk("return_src",      16'(src),      16'h0);
        chk("return_play_dat", 16'(snd_dat),  16'hF0);
        chk("return_den",      16'(decay_en), 16'h0);
        n = 0;
        do begin tick_step(); n++; end while (decay_en !== 1'b1 && n < 3 * H);
        chk("return_rehold", 16'(n), 16'(H + 1));
        decay_req = 1'b0;
`endif

        // random traffic against the model
        smp_seq = 1'b0;
        for (int i = 0; i < 60 * N; i++) begin
            cpu_wr  = ($urandom_range(0, 29) == 0);
            cpu_dat = 8'($urandom);
            if (is_dec(cyc + 1) && $urandom_range(0, 5) == 0) decay_req = ~decay_req;
            if ($urandom_range(0, 9) == 0) smp_req = ~smp_req;
            smp_dat = 8'($urandom);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
